spi_arbiter: RTL and testbench

- Two-requester round-robin arbiter and transaction sequencer in front of the SPI interface block.
- Requester 0 is the core load/store path; requester 1 is the boot/debug loader.
- Grants one requester at a time and sequences a full write or read frame on the SPI interface.
- Returns an ack pulse, an error flag and the latched read data / address.

---
 rtl/spi_arbiter.sv | 113 +++++++++++
 tb/tb_spi_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_arbiter.sv
// spi_arbiter: two-requester round-robin arbiter that sequences one SPI write or read frame per grant
module spi_arbiter #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 4,
   parameter int FRAME_LEN = DATA_W + ADDR_W,
   parameter int TMO_SLACK = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        req_in,
   input  logic [1:0]        we_in,
   input  logic [DATA_W-1:0] wdata0_in,
   input  logic [DATA_W-1:0] wdata1_in,
   output logic [1:0]        ack_out,
   output logic [1:0]        err_out,
   output logic [DATA_W-1:0] rsp_rdata_out,
   output logic [ADDR_W-1:0] rsp_addr_out,
   output logic              gnt_out,
   output logic              busy_out,
   output logic              spi_send_out,
   output logic              spi_read_out,
   output logic [DATA_W-1:0] spi_wdata_out,
   input  logic              spi_ready_in,
   input  logic [DATA_W-1:0] spi_rdata_in,
   input  logic [ADDR_W-1:0] spi_addr_in
);
   localparam int CNT_W = $clog2(FRAME_LEN + TMO_SLACK) + 1;
   localparam logic [CNT_W-1:0] WR_LAST  = CNT_W'(FRAME_LEN - 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(FRAME_LEN + TMO_SLACK - 1);

   typedef enum logic [2:0] {IDLE, ISSUE, BUSY, LATCH, ACK} state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_dir;
   logic             w_idx;
   logic             w_we;
   logic [DATA_W-1:0] w_wdata;
   logic [1:0]       w_ack;

   // round-robin pick: on a tie the requester that was not granted last wins
   always_comb begin
      w_idx   = (req_in == 2'b11) ? ~gnt_out : req_in[1];
      w_we    = we_in[w_idx];
      w_wdata = w_idx ? wdata1_in : wdata0_in;
      w_ack   = gnt_out ? 2'b10 : 2'b01;
   end

   // frame sequencer; every output is registered so strobes line up with the state they belong to
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= IDLE;
         r_cnt         <= '0;
         r_dir         <= 1'b0;
         gnt_out       <= 1'b1;
         ack_out       <= '0;
         err_out       <= '0;
         rsp_rdata_out <= '0;
         rsp_addr_out  <= '0;
         busy_out      <= 1'b0;
         spi_send_out  <= 1'b0;
         spi_read_out  <= 1'b0;
         spi_wdata_out <= '0;
      end else begin
         ack_out <= '0;
         err_out <= '0;
         case (r_state)
            IDLE: if (|req_in) begin
               gnt_out       <= w_idx;
               r_dir         <= w_we;
               spi_wdata_out <= w_wdata;
               spi_send_out  <= w_we;
               spi_read_out  <= ~w_we;
               busy_out      <= 1'b1;
               r_state       <= ISSUE;
            end
            ISSUE: begin
               r_cnt        <= '0;
               spi_send_out <= 1'b0;
               r_state      <= BUSY;
            end
            BUSY: begin
               r_cnt <= r_cnt + 1'b1;
               if (r_dir) begin
                  if (r_cnt == WR_LAST) begin
                     ack_out <= w_ack;
                     r_state <= ACK;
                  end
               end else if (spi_ready_in) begin
                  spi_read_out <= 1'b0;
                  r_state      <= LATCH;
               end else if (r_cnt == TMO_LAST) begin
                  spi_read_out <= 1'b0;
                  ack_out      <= w_ack;
                  err_out      <= w_ack;
                  r_state      <= ACK;
               end
            end
            LATCH: begin
               rsp_rdata_out <= spi_rdata_in;
               rsp_addr_out  <= spi_addr_in;
               ack_out       <= w_ack;
               r_state       <= ACK;
            end
            ACK: begin
               busy_out <= 1'b0;
               r_state  <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: directed scenarios plus a randomized run against a transaction-level model
module tb_spi_arbiter;
   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] req_in, we_in, ack_out, err_out;
   logic [7:0] wdata0_in, wdata1_in, rsp_rdata_out, spi_wdata_out, spi_rdata_in;
   logic [3:0] rsp_addr_out, spi_addr_in;
   logic       gnt_out, busy_out, spi_send_out, spi_read_out, spi_ready_in;
   int         vec = 0;
   int         bad = 0;

   spi_arbiter dut (
      .clk(clk), .rst(rst), .req_in(req_in), .we_in(we_in),
      .wdata0_in(wdata0_in), .wdata1_in(wdata1_in),
      .ack_out(ack_out), .err_out(err_out),
      .rsp_rdata_out(rsp_rdata_out), .rsp_addr_out(rsp_addr_out),
      .gnt_out(gnt_out), .busy_out(busy_out),
      .spi_send_out(spi_send_out), .spi_read_out(spi_read_out), .spi_wdata_out(spi_wdata_out),
      .spi_ready_in(spi_ready_in), .spi_rdata_in(spi_rdata_in), .spi_addr_in(spi_addr_in)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1; req_in = '0; we_in = '0; wdata0_in = '0; wdata1_in = '0;
      spi_ready_in = 1'b0; spi_rdata_in = '0; spi_addr_in = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset;
      do_reset();
      @(negedge clk);
      vec++;
      if ({busy_out, spi_send_out, spi_read_out, ack_out, err_out, gnt_out} !== 8'b0000_0001) begin
         bad++;
         $display("FAIL reset ctl got %b exp 00000001", {busy_out, spi_send_out, spi_read_out, ack_out, err_out, gnt_out});
      end
      vec++;
      if ({rsp_rdata_out, rsp_addr_out, spi_wdata_out} !== 20'h0) begin
         bad++;
         $display("FAIL reset data got %h exp 00000", {rsp_rdata_out, rsp_addr_out, spi_wdata_out});
      end
      tick();
   endtask

   task automatic test_write;
      logic [2:0] e;
      do_reset();
      for (int c = 0; c <= 16; c++) begin
         req_in = (c < 14) ? 2'b01 : 2'b00;
         if (c == 0) begin we_in = 2'b01; wdata0_in = 8'hA5; end
         else begin we_in = 2'($urandom); wdata0_in = 8'($urandom); end
         @(negedge clk);
         e = {c >= 1 && c <= 14, c == 1, 1'b0};
         vec++;
         if ({busy_out, spi_send_out, spi_read_out} !== e) begin
            bad++;
            $display("FAIL write c=%0d busy/send/read got %b exp %b", c, {busy_out, spi_send_out, spi_read_out}, e);
         end
         vec++;
         if ({ack_out, err_out} !== ((c == 14) ? 4'b0100 : 4'b0000)) begin
            bad++;
            $display("FAIL write c=%0d ack/err got %b exp %b", c, {ack_out, err_out}, (c == 14) ? 4'b0100 : 4'b0000);
         end
         if (c >= 1 && c <= 14) begin
            vec++;
            if (spi_wdata_out !== 8'hA5) begin
               bad++;
               $display("FAIL write c=%0d wdata got %h exp a5", c, spi_wdata_out);
            end
         end
         tick();
      end
   endtask

   task automatic test_read;
      logic [2:0] e;
      for (int c = 0; c <= 16; c++) begin
         req_in = (c < 15) ? 2'b10 : 2'b00;
         we_in = 2'b00;
         spi_ready_in = (c == 13);
         if (c == 13) begin spi_rdata_in = 8'h3C; spi_addr_in = 4'h9; end
         @(negedge clk);
         e = {c >= 1 && c <= 15, 1'b0, c >= 1 && c <= 13};
         vec++;
         if ({busy_out, spi_send_out, spi_read_out} !== e) begin
            bad++;
            $display("FAIL read c=%0d busy/send/read got %b exp %b", c, {busy_out, spi_send_out, spi_read_out}, e);
         end
         vec++;
         if ({ack_out, err_out} !== ((c == 15) ? 4'b1000 : 4'b0000)) begin
            bad++;
            $display("FAIL read c=%0d ack/err got %b exp %b", c, {ack_out, err_out}, (c == 15) ? 4'b1000 : 4'b0000);
         end
         if (c >= 15) begin
            vec++;
            if ({rsp_rdata_out, rsp_addr_out, gnt_out} !== {8'h3C, 4'h9, 1'b1}) begin
               bad++;
               $display("FAIL read c=%0d rsp/gnt got %h/%h/%b exp 3c/9/1", c, rsp_rdata_out, rsp_addr_out, gnt_out);
            end
         end
         tick();
      end
      spi_ready_in = 1'b0;
   endtask

   task automatic test_timeout;
      logic [1:0] e;
      for (int c = 0; c <= 17; c++) begin
         req_in = (c < 16) ? 2'b01 : 2'b00;
         we_in = 2'b00;
         spi_ready_in = 1'b0;
         spi_rdata_in = 8'($urandom);
         spi_addr_in = 4'($urandom);
         @(negedge clk);
         vec++;
         if ({busy_out, spi_read_out} !== {c >= 1 && c <= 16, c >= 1 && c <= 15}) begin
            bad++;
            $display("FAIL timeout c=%0d busy/read got %b exp %b", c, {busy_out, spi_read_out}, {c >= 1 && c <= 16, c >= 1 && c <= 15});
         end
         e = (c == 16) ? 2'b01 : 2'b00;
         vec++;
         if ({ack_out, err_out} !== {e, e}) begin
            bad++;
            $display("FAIL timeout c=%0d ack/err got %b exp %b", c, {ack_out, err_out}, {e, e});
         end
         vec++;
         if ({rsp_rdata_out, rsp_addr_out} !== {8'h3C, 4'h9}) begin
            bad++;
            $display("FAIL timeout c=%0d rsp got %h/%h exp 3c/9", c, rsp_rdata_out, rsp_addr_out);
         end
         tick();
      end
   endtask

   task automatic test_alternate;
      logic [1:0] e;
      do_reset();
      for (int c = 0; c <= 61; c++) begin
         req_in = (c < 60) ? 2'b11 : 2'b00;
         we_in = 2'b11;
         wdata0_in = 8'($urandom);
         wdata1_in = 8'($urandom);
         @(negedge clk);
         e = (c < 60 && c % 15 == 14) ? (((c / 15) % 2 == 1) ? 2'b10 : 2'b01) : 2'b00;
         vec++;
         if (ack_out !== e) begin
            bad++;
            $display("FAIL alternate c=%0d ack got %b exp %b", c, ack_out, e);
         end
         vec++;
         if (spi_send_out !== (c < 60 && c % 15 == 1)) begin
            bad++;
            $display("FAIL alternate c=%0d send got %b exp %b", c, spi_send_out, c < 60 && c % 15 == 1);
         end
         if (c < 60 && c % 15 == 1) begin
            vec++;
            if (gnt_out !== 1'((c / 15) % 2)) begin
               bad++;
               $display("FAIL alternate c=%0d gnt got %b exp %0d", c, gnt_out, (c / 15) % 2);
            end
         end
         tick();
      end
   endtask

   task automatic test_reset_mid;
      do_reset();
      for (int c = 0; c <= 6; c++) begin
         req_in = 2'b01; we_in = 2'b01; wdata0_in = 8'h5A;
         rst = (c == 6);
         @(negedge clk);
         if (c == 5) begin
            vec++;
            if ({busy_out, gnt_out} !== 2'b10) begin
               bad++;
               $display("FAIL rstmid pre busy/gnt got %b exp 10", {busy_out, gnt_out});
            end
         end
         tick();
      end
      rst = 1'b0; req_in = 2'b00;
      for (int c = 7; c <= 10; c++) begin
         @(negedge clk);
         vec++;
         if ({busy_out, spi_send_out, spi_read_out, spi_wdata_out, ack_out, gnt_out} !== 14'b000_00000000_00_1) begin
            bad++;
            $display("FAIL rstmid c=%0d got %b exp 00000000000001", c, {busy_out, spi_send_out, spi_read_out, spi_wdata_out, ack_out, gnt_out});
         end
         tick();
      end
      for (int c = 0; c <= 16; c++) begin
         req_in = (c < 14) ? 2'b11 : 2'b00;
         we_in = 2'b11;
         @(negedge clk);
         if (c == 1) begin
            vec++;
            if ({gnt_out, spi_send_out} !== 2'b01) begin
               bad++;
               $display("FAIL rstmid regrant gnt/send got %b exp 01", {gnt_out, spi_send_out});
            end
         end
         vec++;
         if (ack_out !== ((c == 14) ? 2'b01 : 2'b00)) begin
            bad++;
            $display("FAIL rstmid c=%0d ack got %b exp %b", c, ack_out, (c == 14) ? 2'b01 : 2'b00);
         end
         tick();
      end
   endtask

   task automatic test_drop;
      logic [7:0] d;
      logic [3:0] a;
      d = 8'($urandom);
      a = 4'($urandom);
      for (int c = 0; c <= 16; c++) begin
         req_in = (c < 3) ? 2'b10 : 2'b00;
         we_in = 2'b00;
         spi_ready_in = (c == 13);
         spi_rdata_in = d;
         spi_addr_in = a;
         @(negedge clk);
         vec++;
         if ({busy_out, ack_out} !== {c >= 1 && c <= 15, (c == 15) ? 2'b10 : 2'b00}) begin
            bad++;
            $display("FAIL drop c=%0d busy/ack got %b exp %b", c, {busy_out, ack_out}, {c >= 1 && c <= 15, (c == 15) ? 2'b10 : 2'b00});
         end
         if (c >= 15) begin
            vec++;
            if ({rsp_rdata_out, rsp_addr_out} !== {d, a}) begin
               bad++;
               $display("FAIL drop c=%0d rsp got %h/%h exp %h/%h", c, rsp_rdata_out, rsp_addr_out, d, a);
            end
         end
         tick();
      end
      spi_ready_in = 1'b0;
   endtask

   task automatic test_random;
      bit         act = 0, we_m = 0, tmo = 0;
      logic       idx = 1'b0, last = 1'b1;
      int         g = 0, rdy = 0, fin = 0, t, acks = 0;
      logic [7:0] wd = '0, rd = '0, exp_rd = '0;
      logic [3:0] ad = '0, exp_ad = '0;
      logic [1:0] oh, ea, ee;
      logic [8:0] exp_ctl;
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         t = c - g;
         req_in = 2'($urandom);
         we_in = 2'($urandom);
         wdata0_in = 8'($urandom);
         wdata1_in = 8'($urandom);
         if (act && !we_m) begin
            spi_ready_in = (t == rdy);
            spi_rdata_in = rd;
            spi_addr_in = ad;
         end else begin
            spi_ready_in = ($urandom_range(0, 3) == 0);
            spi_rdata_in = 8'($urandom);
            spi_addr_in = 4'($urandom);
         end
         oh = idx ? 2'b10 : 2'b01;
         ea = (act && t == fin) ? oh : 2'b00;
         ee = (act && t == fin && tmo) ? oh : 2'b00;
         if (act && t == fin) begin
            acks++;
            if (!we_m && !tmo) begin exp_rd = rd; exp_ad = ad; end
         end
         exp_ctl = {act, act && we_m && t == 1, act && !we_m && t <= (tmo ? 15 : rdy), ea, ee, last};
         @(negedge clk);
         vec++;
         if ({busy_out, spi_send_out, spi_read_out, ack_out, err_out, gnt_out} !== exp_ctl) begin
            bad++;
            $display("FAIL random c=%0d busy/send/read/ack/err/gnt got %b exp %b", c, {busy_out, spi_send_out, spi_read_out, ack_out, err_out, gnt_out}, exp_ctl);
         end
         vec++;
         if ({rsp_rdata_out, rsp_addr_out} !== {exp_rd, exp_ad}) begin
            bad++;
            $display("FAIL random c=%0d rsp got %h/%h exp %h/%h", c, rsp_rdata_out, rsp_addr_out, exp_rd, exp_ad);
         end
         if (act) begin
            vec++;
            if (spi_wdata_out !== wd) begin
               bad++;
               $display("FAIL random c=%0d wdata got %h exp %h", c, spi_wdata_out, wd);
            end
         end
         if (act && t == fin) act = 0;
         else if (!act && req_in != 2'b00) begin
            idx = (req_in == 2'b11) ? ~last : req_in[1];
            last = idx;
            we_m = we_in[idx];
            wd = idx ? wdata1_in : wdata0_in;
            rd = 8'($urandom);
            ad = 4'($urandom);
            rdy = $urandom_range(2, 17);
            tmo = !we_m && rdy > 15;
            fin = we_m ? 14 : (tmo ? 16 : rdy + 2);
            g = c;
            act = 1;
         end
         tick();
      end
      vec++;
      if (acks < 20) begin
         bad++;
         $display("FAIL random ack count got %0d exp >= 20", acks);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_timeout();
      test_alternate();
      test_reset_mid();
      test_drop();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end
endmodule
